// File: rtl/axi_rd_arbiter.sv
// Two-master (I-cache / D-cache) to single AXI3 read port arbiter.
// One read outstanding at a time; round-robin on contention; R data routed by FSM state.
module axi_rd_arbiter #(
    parameter logic [3:0] I_ID = 4'd0,
    parameter logic [3:0] D_ID = 4'd1
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,

    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [2:0]  o_dbg_state
);

    // Handshakes: a transfer happens on the rising edge where valid && ready.
    // The arbiter raises i/d_arready only in the IDLE cycle it grants; AR holds
    // arvalid with stable fields until arready; R beats are forwarded combinationally.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR_I = 3'd1,
        AR_D = 3'd2,
        R_I  = 3'd3,
        R_D  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last_d;
    logic [3:0]  r_arid;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic [2:0]  r_arsize;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_r_done;
    logic        w_unused;

    // rid/rresp carry no routing meaning here: data follows the owning state.
    assign w_unused = ^{rid, rresp};

    always_comb begin
        w_next    = r_state;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        w_r_done  = rvalid && rready && rlast;
        case (r_state)
            IDLE: begin
                // Gated by aresetn so arready stays low while reset is held.
                w_grant_i = aresetn && i_arvalid && (!d_arvalid || r_last_d);
                w_grant_d = aresetn && d_arvalid && (!i_arvalid || !r_last_d);
                if (w_grant_i) begin
                    w_next = AR_I;
                end else if (w_grant_d) begin
                    w_next = AR_D;
                end
            end
            AR_I: if (arready) w_next = R_I;
            AR_D: if (arready) w_next = R_D;
            R_I:  if (w_r_done) w_next = IDLE;
            R_D:  if (w_r_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
            r_arid   <= 4'd0;
            r_araddr <= 32'd0;
            r_arlen  <= 8'd0;
            r_arsize <= 3'd0;
        end else begin
            r_state <= w_next;
            if (w_grant_i) begin
                r_last_d <= 1'b0;
                r_arid   <= I_ID;
                r_araddr <= i_araddr;
                r_arlen  <= i_arlen;
                r_arsize <= i_arsize;
            end else if (w_grant_d) begin
                r_last_d <= 1'b1;
                r_arid   <= D_ID;
                r_araddr <= d_araddr;
                r_arlen  <= d_arlen;
                r_arsize <= d_arsize;
            end
        end
    end

    assign i_arready = w_grant_i;
    assign d_arready = w_grant_d;

    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arlen   = r_arlen;
    assign arsize  = r_arsize;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (r_state == AR_I) || (r_state == AR_D);

    assign rready = ((r_state == R_I) && i_rready) || ((r_state == R_D) && d_rready);

    assign i_rdata  = rdata;
    assign i_rlast  = (r_state == R_I) && rlast;
    assign i_rvalid = (r_state == R_I) && rvalid;
    assign d_rdata  = rdata;
    assign d_rlast  = (r_state == R_D) && rlast;
    assign d_rvalid = (r_state == R_D) && rvalid;

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed I/D traffic, a transaction-level model
// checked every cycle, plus literal expectations at key points.
module tb_axi_rd_arbiter;

  localparam logic [3:0] I_ID = 4'd0;
  localparam logic [3:0] D_ID = 4'd1;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [31:0] i_araddr, d_araddr, i_rdata, d_rdata, araddr, rdata;
  logic [7:0]  i_arlen, d_arlen, arlen;
  logic [2:0]  i_arsize, d_arsize, arsize, arprot, o_dbg_state;
  logic        i_arvalid, d_arvalid, i_arready, d_arready;
  logic        i_rlast, i_rvalid, i_rready, d_rlast, d_rvalid, d_rready;
  logic [3:0]  arid, arcache, rid;
  logic [1:0]  arburst, arlock, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;

  axi_rd_arbiter #(.I_ID(I_ID), .D_ID(D_ID)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
    .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: who owns the bus (-1 none, 0 I, 1 D), whether its address
  // is still waiting for arready, and who was served last.
  int          m_owner = -1;
  bit          m_addr_ph = 1'b0;
  bit          m_last_d = 1'b0;
  logic [31:0] m_addr = '0;
  logic [7:0]  m_len = '0;
  logic [2:0]  m_size = '0;

  function automatic int pick();
    if (m_owner >= 0) return -1;
    if (i_arvalid && d_arvalid) return m_last_d ? 0 : 1;
    if (i_arvalid) return 0;
    if (d_arvalid) return 1;
    return -1;
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_owner   <= -1;
      m_addr_ph <= 1'b0;
      m_last_d  <= 1'b0;
    end else if (m_owner < 0) begin
      if (pick() >= 0) begin
        m_owner   <= pick();
        m_addr_ph <= 1'b1;
        m_last_d  <= (pick() == 1);
        m_addr    <= (pick() == 1) ? d_araddr : i_araddr;
        m_len     <= (pick() == 1) ? d_arlen : i_arlen;
        m_size    <= (pick() == 1) ? d_arsize : i_arsize;
      end
    end else if (m_addr_ph) begin
      if (arready) m_addr_ph <= 1'b0;
    end else if (rvalid && rlast && ((m_owner == 1) ? d_rready : i_rready)) begin
      m_owner <= -1;
    end
  end

  always @(negedge aclk) begin
    int eg;
    bit in_data;
    bit e_irv;
    bit e_drv;
    if (!aresetn) begin
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_i_arready", i_arready, 0);
      chk("rst_d_arready", d_arready, 0);
      chk("rst_i_rvalid", i_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_arlen", arlen, 0);
      chk("rst_arsize", arsize, 0);
      chk("rst_arid", arid, 0);
    end else begin
      eg = pick();
      in_data = (m_owner >= 0) && !m_addr_ph;
      e_irv = in_data && (m_owner == 0) && rvalid;
      e_drv = in_data && (m_owner == 1) && rvalid;
      chk("m_i_arready", i_arready, eg == 0);
      chk("m_d_arready", d_arready, eg == 1);
      chk("m_arvalid", arvalid, (m_owner >= 0) && m_addr_ph);
      if ((m_owner >= 0) && m_addr_ph) begin
        chk("m_araddr", araddr, m_addr);
        chk("m_arlen", arlen, m_len);
        chk("m_arsize", arsize, m_size);
        chk("m_arid", arid, (m_owner == 1) ? D_ID : I_ID);
      end
      chk("m_arburst", arburst, 2'b01);
      chk("m_arconst", {arlock, arcache, arprot}, 0);
      chk("m_rready", rready, in_data && ((m_owner == 1) ? d_rready : i_rready));
      chk("m_i_rvalid", i_rvalid, e_irv);
      chk("m_d_rvalid", d_rvalid, e_drv);
      if (e_irv) begin
        chk("m_i_rdata", i_rdata, rdata);
        chk("m_i_rlast", i_rlast, rlast);
      end
      if (e_drv) begin
        chk("m_d_rdata", d_rdata, rdata);
        chk("m_d_rlast", d_rlast, rlast);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // AXI slave: waits for arvalid, stalls arready ar_delay cycles, then returns
  // nbeats beats. stop_after>0 leaves the burst unfinished after that many beats.
  task automatic slave_serve(input int ar_delay, input int nbeats, input int who,
                             input bit toggle, input int stop_after, input logic [31:0] base,
                             output int accepted, output int seen, output int last_at);
    int n;
    int cyc;
    logic [31:0] a;
    accepted = 0;
    seen = 0;
    last_at = 0;
    n = 0;
    while (!arvalid && n < 20) begin
      tick();
      n++;
    end
    chk("ar_wait", arvalid, 1);
    a = araddr;
    for (int k = 0; k < ar_delay; k++) begin
      chk("ar_hold_valid", arvalid, 1);
      chk("ar_hold_addr", araddr, a);
      tick();
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("ar_done", arvalid, 0);
    cyc = 0;
    while (accepted < nbeats && cyc < 100 && !(stop_after > 0 && accepted == stop_after)) begin
      rvalid = 1'b1;
      rdata  = base + accepted;
      rlast  = (accepted == nbeats - 1);
      rid    = 4'($urandom_range(0, 15));
      rresp  = 2'($urandom_range(0, 3));
      if (toggle) begin
        if (who == 1) d_rready = (cyc % 2 == 0);
        else i_rready = (cyc % 2 == 0);
      end
      #1;
      if (who == 0 && i_rvalid && i_rready) begin
        seen++;
        if (i_rlast) last_at = seen;
      end
      if (who == 1 && d_rvalid && d_rready) begin
        seen++;
        if (d_rlast) last_at = seen;
      end
      if (rready) accepted++;
      cyc++;
      tick();
    end
    chk("beat_budget", cyc < 100, 1);
    if (stop_after == 0) begin
      rvalid = 1'b0;
      rlast  = 1'b0;
    end
    i_rready = 1'b1;
    d_rready = 1'b1;
  endtask

  // ---------------- directed stimulus ----------------
  int acc, seen, last_at;

  initial begin
    i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arvalid = 1'b0; i_rready = 1'b1;
    d_araddr = '0; d_arlen = '0; d_arsize = '0; d_arvalid = 1'b0; d_rready = 1'b1;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;

    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    chk("post_rst_arvalid", arvalid, 0);
    chk("post_rst_arid", arid, 0);
    tick();

    // Single I burst of 8
    i_araddr = 32'hBFC0_0000; i_arlen = 8'd7; i_arsize = 3'd2; i_arvalid = 1'b1;
    #1;
    chk("t1_i_arready", i_arready, 1);
    chk("t1_d_arready", d_arready, 0);
    tick();
    i_arvalid = 1'b0;
    chk("t1_i_arready_gone", i_arready, 0);
    chk("t1_arvalid", arvalid, 1);
    chk("t1_arid", arid, 0);
    chk("t1_arburst", arburst, 1);
    chk("t1_araddr", araddr, 32'hBFC0_0000);
    chk("t1_arlen", arlen, 7);
    slave_serve(0, 8, 0, 1'b0, 0, 32'h1000_0000, acc, seen, last_at);
    chk("t1_accepted", acc, 8);
    chk("t1_seen", seen, 8);
    chk("t1_last_at", last_at, 8);
    chk("t1_idle_rready", rready, 0);

    // Contention straight after reset: D first, then I, then alternate
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    i_araddr = 32'h0000_1000; i_arlen = 8'd0; i_arvalid = 1'b1;
    d_araddr = 32'h8000_0040; d_arlen = 8'd1; d_arsize = 3'd2; d_arvalid = 1'b1;
    #1;
    chk("t2_d_first", d_arready, 1);
    chk("t2_i_wait", i_arready, 0);
    tick();
    d_arvalid = 1'b0;
    chk("t2_arid_d", arid, 1);
    chk("t2_araddr_d", araddr, 32'h8000_0040);
    slave_serve(0, 2, 1, 1'b0, 0, 32'h2000_0000, acc, seen, last_at);
    chk("t2_d_beats", seen, 2);
    chk("t2_i_next", i_arready, 1);
    tick();
    i_arvalid = 1'b0;
    chk("t2_arid_i", arid, 0);
    slave_serve(0, 1, 0, 1'b0, 0, 32'h2100_0000, acc, seen, last_at);
    d_arlen = 8'd0;
    for (int r = 0; r < 4; r++) begin
      i_araddr = 32'h0000_2000 + r; d_araddr = 32'h8000_0080 + r;
      i_arvalid = 1'b1; d_arvalid = 1'b1;
      #1;
      chk("t2_alt_d", d_arready, (r % 2 == 0));
      chk("t2_alt_i", i_arready, (r % 2 == 1));
      tick();
      i_arvalid = 1'b0; d_arvalid = 1'b0;
      slave_serve(0, 1, (r % 2 == 0) ? 1 : 0, 1'b0, 0, 32'h3000_0000 + r, acc, seen, last_at);
      chk("t2_alt_beat", seen, 1);
    end

    // AR backpressure: arready low for 5 cycles
    d_araddr = 32'h4000_0000; d_arlen = 8'd3; d_arvalid = 1'b1;
    #1;
    chk("t3_d_grant", d_arready, 1);
    tick();
    d_arvalid = 1'b0;
    slave_serve(5, 4, 1, 1'b0, 0, 32'h4400_0000, acc, seen, last_at);
    chk("t3_accepted", acc, 4);

    // R backpressure: d_rready toggling during a 4-beat burst
    d_araddr = 32'h5000_0000; d_arlen = 8'd3; d_arvalid = 1'b1;
    tick();
    d_arvalid = 1'b0;
    slave_serve(0, 4, 1, 1'b1, 0, 32'h5500_0000, acc, seen, last_at);
    chk("t4_accepted", acc, 4);
    chk("t4_seen", seen, 4);
    chk("t4_last_at", last_at, 4);

    // Single-beat read, then a new request granted in the following IDLE cycle
    i_araddr = 32'h6000_0000; i_arlen = 8'd0; i_arvalid = 1'b1;
    tick();
    i_arvalid = 1'b0;
    slave_serve(0, 1, 0, 1'b0, 0, 32'h6600_0000, acc, seen, last_at);
    chk("t5_last_at", last_at, 1);
    d_araddr = 32'h6800_0000; d_arlen = 8'd0; d_arvalid = 1'b1;
    #1;
    chk("t5_next_grant", d_arready, 1);
    tick();
    d_arvalid = 1'b0;
    slave_serve(0, 1, 1, 1'b0, 0, 32'h6900_0000, acc, seen, last_at);

    // Reset in the middle of an 8-beat D burst
    d_araddr = 32'h7000_0000; d_arlen = 8'd7; d_arvalid = 1'b1;
    tick();
    d_arvalid = 1'b0;
    slave_serve(0, 8, 1, 1'b0, 2, 32'h7700_0000, acc, seen, last_at);
    chk("t6_pre_beats", acc, 2);
    rvalid = 1'b1; rdata = 32'h7700_0002; rlast = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    chk("t6_arvalid", arvalid, 0);
    chk("t6_rready", rready, 0);
    chk("t6_i_rvalid", i_rvalid, 0);
    chk("t6_d_rvalid", d_rvalid, 0);
    rvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    i_araddr = 32'h0000_9000; i_arlen = 8'd0; i_arvalid = 1'b1;
    d_araddr = 32'h8000_9000; d_arlen = 8'd0; d_arvalid = 1'b1;
    #1;
    chk("t6_d_after_rst", d_arready, 1);
    chk("t6_i_after_rst", i_arready, 0);
    tick();
    d_arvalid = 1'b0;
    slave_serve(0, 1, 1, 1'b0, 0, 32'h9100_0000, acc, seen, last_at);
    chk("t6_i_follow", i_arready, 1);
    tick();
    i_arvalid = 1'b0;
    slave_serve(0, 1, 0, 1'b0, 0, 32'h9200_0000, acc, seen, last_at);
    chk("t6_i_beat", seen, 1);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter I_ID, default 4'd0, the ARID driven for instruction-cache requests.
REQ-002 SHALL have parameter D_ID, default 4'd1, the ARID driven for data-cache requests.
REQ-003 SHALL have port aclk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port aresetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports i_araddr/i_arlen/i_arsize/i_arvalid  input  32/8/3/1  I-cache read request.
REQ-006 SHALL have port i_arready  output  1  I-cache request accepted.
REQ-007 SHALL have ports i_rdata/i_rlast/i_rvalid  output  32/1/1  and i_rready  input  1  for the I-cache read data return.
REQ-008 SHALL have ports d_araddr/d_arlen/d_arsize/d_arvalid  input  32/8/3/1  and d_arready  output  1  for the D-cache read request.
REQ-009 SHALL have ports d_rdata/d_rlast/d_rvalid  output  32/1/1  and d_rready  input  1  for the D-cache read data return.
REQ-010 SHALL have ports arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  output  4/32/8/3/2/2/4/3/1  and arready  input  1  as the AXI3 read-address channel.
REQ-011 SHALL have ports rid/rdata/rresp/rlast/rvalid  input  4/32/2/1/1  and rready  output  1  as the AXI3 read-data channel.

Function
REQ-012 SHALL implement the states IDLE, AR_I, AR_D, R_I and R_D, with only one AXI read outstanding at any time.
REQ-013 SHALL in IDLE with only one of i_arvalid or d_arvalid high grant that master.
REQ-014 SHALL in IDLE with both i_arvalid and d_arvalid high grant the master not granted last (round-robin).
REQ-015 SHALL drive the granted master's arready combinationally high in the grant cycle only, and drive both i_arready and d_arready low in every other state.
REQ-016 SHALL on a grant latch addr, len and size into the AR output registers, set arid to I_ID or D_ID, and move to AR_I or AR_D on the next edge.
REQ-017 SHALL hold arvalid high with stable AR fields throughout AR_x until arready=1, then move to R_x on that edge.
REQ-018 SHALL drive constants arburst=2'b01 (INCR), arlock=0, arcache=0 and arprot=0.
REQ-019 SHALL in R_x drive rready=x_rready and x_rvalid=rvalid, and pass rdata and rlast to x_rdata and x_rlast.
REQ-020 SHALL in R_x hold the other master's rvalid at 0.
REQ-021 SHALL outside R states drive rready=0 and both master rvalids to 0.
REQ-022 SHALL route read data by state, not by rid; rid and rresp are ignored.
REQ-023 SHALL return from R_x to IDLE on the edge where rvalid&rready&rlast=1.
REQ-024 SHALL leave one IDLE cycle between transactions.
REQ-025 SHALL achieve minimum latency of grant cycle → arvalid on the next cycle → first beat forwarded the same cycle it arrives, with no added R-path latency.
REQ-026 SHALL update the last-granted pointer only on a grant.
REQ-027 SHALL handle an arlen=0 single beat with rlast on the first beat as a normal transaction ending in IDLE.
REQ-028 SHALL ignore a master that drops arvalid before being granted, with no state change.

Reset
REQ-029 SHALL while aresetn=0 asynchronously force the state to IDLE, arvalid=0, rready=0, i/d_arready=0, i/d_rvalid=0, araddr=0, arlen=0, arsize=0 and arid=0.
REQ-030 SHALL set last-granted=I at reset, so the first contended grant goes to D.
REQ-031 SHALL on a reset asserted mid-transaction abandon the transaction, drop outstanding beats and forward nothing.

Verification
REQ-032 SHALL verify a single I request: i_araddr=0xBFC00000, arlen=7 → i_arready for 1 cycle, arvalid next cycle with arid=0 and arburst=1; 8 beats routed to the I side with i_rlast on beat 8; IDLE after.
REQ-033 SHALL verify contention after reset: both request simultaneously → D granted first (arid=1); after D's rlast and one IDLE cycle I is granted; a second simultaneous request is then granted D again, alternating.
REQ-034 SHALL verify arready backpressure: arready low for 5 cycles → arvalid and araddr stable for all 5 cycles; transition to R on the first arready=1 edge.
REQ-035 SHALL verify R backpressure: d_rready toggles 1/0 during a 4-beat burst → rready mirrors d_rready, i_rvalid=0 throughout, and exactly 4 beats are accepted.
REQ-036 SHALL verify single-beat reads: arlen=0 with rlast on beat 1 → return to IDLE; a new request is granted one cycle later.
REQ-037 SHALL verify reset mid-burst: aresetn=0 after beat 2 of 8 → arvalid, rready, i_rvalid and d_rvalid all 0 immediately (asynchronously); state IDLE after release.
